// File: rtl/falu_sequencer.sv
// falu_sequencer: buffers FP ALU commands in a FIFO, issues them one at a time, and returns results over ready/valid.
// Ports: cmd_* is the command push side (cmd_ready = !full) and alu_* is the ALU issue/result side.
// rsp_* is the response side, held until rsp_ready. sticky_flags is the OR of the captured ALU flags,
// and sticky_clr clears it. busy = FSM active or FIFO non-empty.
module falu_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_mode,
  input  logic        cmd_rnd,
  output logic        alu_start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_mode,
  output logic        alu_rnd,
  input  logic [31:0] alu_result,
  input  logic        alu_valid,
  input  logic [4:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic [4:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        r_state, w_next;
  logic [67:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [CW-1:0] r_wcnt;
  logic          w_full, w_empty, w_push, w_pop, w_cap, w_tout;
  // full/empty come straight from the registered count, so a pop never frees a slot for a same-cycle push
  assign w_full    = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_empty   = r_cnt == '0;
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = r_state == IDLE && !w_empty;
  assign w_cap     = r_state == WAIT && alu_valid;
  // a valid arriving in the last wait cycle takes priority over the timeout
  assign w_tout    = r_state == WAIT && !alu_valid && r_wcnt == CW'(TIMEOUT - 1);
  assign alu_start = r_state == ISSUE;
  assign rsp_valid = r_state == RESP;
  assign busy      = r_state != IDLE || !w_empty;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_empty ? IDLE : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (w_cap || w_tout) ? RESP : WAIT;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {cmd_a, cmd_b, cmd_op, cmd_mode, cmd_rnd};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_wcnt       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_mode     <= 1'b0;
      alu_rnd      <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_timeout  <= 1'b0;
      sticky_flags <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_pop) {alu_a, alu_b, alu_op, alu_mode, alu_rnd} <= r_mem[r_rp];
      if (r_state == ISSUE) r_wcnt <= '0;
      else if (r_state == WAIT) r_wcnt <= r_wcnt + 1'b1;
      if (w_cap) {rsp_result, rsp_flags, rsp_timeout} <= {alu_result, alu_flags, 1'b0};
      else if (w_tout) {rsp_result, rsp_flags, rsp_timeout} <= {32'b0, 5'b0, 1'b1};
      if (w_cap) sticky_flags <= sticky_clr ? alu_flags : sticky_flags | alu_flags;
      else if (sticky_clr) sticky_flags <= '0;
    end
  end
endmodule

// File: tb/tb_falu_sequencer.sv
// tb_falu_sequencer: directed and randomized checks of falu_sequencer against a queue-based reference model.
module tb_falu_sequencer;
  localparam int TO = 15;
  typedef struct packed {logic [31:0] a, b; logic [1:0] op; logic mode, rnd;} cmd_t;
  typedef struct {logic [31:0] res; logic [4:0] flg; int dly;} plan_t;
  typedef struct {logic [31:0] res; logic [4:0] flg; logic to;} exp_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_mode = 0, cmd_rnd = 0, rsp_ready = 0, sticky_clr = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0;
  logic [1:0] cmd_op = 0;
  logic m_valid = 0, x_valid = 0, w_valid;
  logic [31:0] alu_result = 0;
  logic [4:0] alu_flags = 0;
  logic cmd_ready, alu_start, alu_mode, alu_rnd, rsp_valid, rsp_timeout, busy;
  logic [31:0] alu_a, alu_b, rsp_result;
  logic [1:0] alu_op;
  logic [4:0] rsp_flags, sticky_flags;
  cmd_t cq[$];
  plan_t pq[$];
  exp_t eq[$];
  int n_cmp = 0, n_err = 0, n_start = 0;
  logic [4:0] m_sticky = 0;
  assign w_valid = m_valid | x_valid;
  always #5 clk = ~clk;
  falu_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_rnd(cmd_rnd),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
    .alu_rnd(alu_rnd), .alu_result(alu_result), .alu_valid(w_valid), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .busy(busy)
  );
  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (alu_start === 1'b1) n_start++;
  // ALU model: answers each start after dly cycles with the planned result (dly 0 = never answers)
  initial begin
    plan_t p;
    cmd_t c;
    forever begin
      tick();
      if (alu_start === 1'b1 && !rst) begin
        chk("start_expected", 68'(pq.size() != 0 && cq.size() != 0), 68'd1);
        if (pq.size() != 0 && cq.size() != 0) begin
          p = pq.pop_front();
          c = cq.pop_front();
          chk("alu_operands", {alu_a, alu_b, alu_op, alu_mode, alu_rnd}, c);
          if (p.dly > 0) begin
            repeat (p.dly) @(posedge clk);
            #1;
            m_valid = 1;
            alu_result = p.res;
            alu_flags = p.flg;
            tick();
            m_valid = 0;
          end
        end
      end
    end
  end
  function automatic cmd_t rcmd();
    cmd_t c;
    c.a = $urandom;
    c.b = $urandom;
    c.op = 2'($urandom);
    c.mode = 1'($urandom);
    c.rnd = 1'($urandom);
    return c;
  endfunction
  function automatic plan_t mkplan(input logic [31:0] res, input logic [4:0] flg, input int dly);
    plan_t p;
    p.res = res;
    p.flg = flg;
    p.dly = dly;
    return p;
  endfunction
  task automatic push(input cmd_t c, input plan_t p);
    int n = 0;
    exp_t e;
    cmd_valid = 1;
    {cmd_a, cmd_b, cmd_op, cmd_mode, cmd_rnd} = c;
    while (cmd_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("push_ready", 68'(cmd_ready), 68'd1);
    tick();
    cmd_valid = 0;
    cq.push_back(c);
    pq.push_back(p);
    // an unanswered command comes back as a timeout with zero payload
    e.res = p.dly == 0 ? 32'd0 : p.res;
    e.flg = p.dly == 0 ? 5'd0 : p.flg;
    e.to = p.dly == 0;
    eq.push_back(e);
  endtask
  task automatic get_rsp(input string tag);
    int n = 0;
    exp_t e;
    while (rsp_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 68'(rsp_valid), 68'd1);
    chk({tag, "_expected"}, 68'(eq.size() != 0), 68'd1);
    if (eq.size() != 0) begin
      e = eq.pop_front();
      chk({tag, "_result"}, 68'(rsp_result), 68'(e.res));
      chk({tag, "_flags"}, 68'(rsp_flags), 68'(e.flg));
      chk({tag, "_timeout"}, 68'(rsp_timeout), 68'(e.to));
      if (!e.to) m_sticky |= e.flg;
    end
    chk({tag, "_sticky"}, 68'(sticky_flags), 68'(m_sticky));
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, "_drop"}, 68'(rsp_valid), 68'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cmd_t c;
    int s0, n;
    logic [31:0] r0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_cmd_ready", 68'(cmd_ready), 68'd1);
    chk("rst_busy", 68'(busy), 68'd0);
    chk("rst_rsp_valid", 68'(rsp_valid), 68'd0);
    chk("rst_alu_start", 68'(alu_start), 68'd0);
    chk("rst_sticky", 68'(sticky_flags), 68'd0);
    chk("rst_alu_ops", {alu_a, alu_b, alu_op, alu_mode, alu_rnd}, 68'd0);
    // single add with cycle-exact timing
    c.a = 32'h3F800000; c.b = 32'h40000000; c.op = 2'b00; c.mode = 1; c.rnd = 0;
    s0 = n_start;
    push(c, mkplan(32'h40400000, 5'd0, 1));
    chk("add_e0_start", 68'(alu_start), 68'd0);
    tick();
    chk("add_e1_start", 68'(alu_start), 68'd1);
    tick();
    chk("add_e2_start", 68'(alu_start), 68'd0);
    chk("add_e2_rsp", 68'(rsp_valid), 68'd0);
    tick();
    chk("add_e3_rsp", 68'(rsp_valid), 68'd1);
    get_rsp("add");
    chk("add_starts", 68'(n_start - s0), 68'd1);
    // backpressure: fill the FIFO while the first response is stalled
    s0 = n_start;
    for (int i = 0; i < 4; i++) push(rcmd(), mkplan($urandom, 5'($urandom), int'($urandom_range(1, 4))));
    chk("bp_ready_3q", 68'(cmd_ready), 68'd1);
    push(rcmd(), mkplan($urandom, 5'($urandom), int'($urandom_range(1, 4))));
    chk("bp_full", 68'(cmd_ready), 68'd0);
    chk("bp_busy", 68'(busy), 68'd1);
    c = rcmd();
    cmd_valid = 1;
    {cmd_a, cmd_b, cmd_op, cmd_mode, cmd_rnd} = c;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    r0 = eq[0].res;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_ready", 68'(cmd_ready), 68'd0);
      chk("bp_stall_valid", 68'(rsp_valid), 68'd1);
      chk("bp_stall_result", 68'(rsp_result), 68'(r0));
    end
    chk("bp_one_start", 68'(n_start - s0), 68'd1);
    cmd_valid = 0;
    get_rsp("bp0");
    push(c, mkplan($urandom, 5'($urandom), int'($urandom_range(1, 4))));
    for (int i = 0; i < 5; i++) get_rsp("bp");
    chk("bp_six_starts", 68'(n_start - s0), 68'd6);
    // timeout: ALU never answers
    push(rcmd(), mkplan(32'hDEADBEEF, 5'h1F, 0));
    repeat (16) tick();
    chk("to_not_yet", 68'(rsp_valid), 68'd0);
    tick();
    chk("to_at_wait_end", 68'(rsp_valid), 68'd1);
    get_rsp("to");
    push(rcmd(), mkplan($urandom, 5'($urandom), 1));
    get_rsp("after_to");
    // sticky accumulation and clear
    sticky_clr = 1;
    tick();
    sticky_clr = 0;
    m_sticky = 0;
    chk("sticky_clr", 68'(sticky_flags), 68'd0);
    c.a = 32'h3F800000; c.b = 32'h0; c.op = 2'b11; c.mode = 1; c.rnd = 0;
    push(c, mkplan(32'h7F800000, 5'b00010, 1));
    get_rsp("div0");
    c.op = 2'b10;
    push(c, mkplan(32'h3F800000, 5'b01001, 1));
    get_rsp("mul");
    chk("sticky_01011", 68'(sticky_flags), 68'b01011);
    push(rcmd(), mkplan($urandom, 5'b00001, 1));
    tick();
    tick();
    sticky_clr = 1;
    tick();
    sticky_clr = 0;
    m_sticky = 0;
    get_rsp("clr_cap");
    // valid in the last wait cycle is a normal capture
    push(rcmd(), mkplan(32'h12345678, 5'b10000, TO));
    repeat (16) tick();
    chk("late_not_yet", 68'(rsp_valid), 68'd0);
    get_rsp("late");
    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      push(rcmd(), mkplan($urandom, 5'($urandom), ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO))));
      get_rsp("rand");
    end
    if (m_sticky == 0) begin
      push(rcmd(), mkplan($urandom, 5'b00100, 1));
      get_rsp("sticky_seed");
    end
    // asynchronous reset while waiting with two commands queued
    for (int i = 0; i < 3; i++) push(rcmd(), mkplan($urandom, 5'($urandom), 0));
    tick();
    tick();
    chk("pre_rst_busy", 68'(busy), 68'd1);
    s0 = n_start;
    #2;
    rst = 1;
    #1;
    chk("arst_alu_start", 68'(alu_start), 68'd0);
    chk("arst_alu_ops", {alu_a, alu_b, alu_op, alu_mode, alu_rnd}, 68'd0);
    chk("arst_rsp", {30'd0, rsp_valid, rsp_result, rsp_flags, rsp_timeout}, 68'd0);
    chk("arst_sticky", 68'(sticky_flags), 68'd0);
    chk("arst_cmd_ready", 68'(cmd_ready), 68'd1);
    chk("arst_busy", 68'(busy), 68'd0);
    tick();
    rst = 0;
    cq.delete();
    pq.delete();
    eq.delete();
    m_sticky = 0;
    for (int i = 0; i < 6; i++) begin
      x_valid = 1'(i % 2 == 0);
      tick();
      chk("post_rst_rsp", 68'(rsp_valid), 68'd0);
      chk("post_rst_busy", 68'(busy), 68'd0);
    end
    x_valid = 0;
    chk("post_rst_starts", 68'(n_start - s0), 68'd0);
    push(rcmd(), mkplan($urandom, 5'($urandom), 2));
    get_rsp("post_rst_op");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/falu_sequencer.md
# falu_sequencer

Command-side driver for the floating-point ALU. It buffers operation requests in a small FIFO and issues them one at a time as single-cycle `start` pulses. It then waits for the ALU's `valid_out`, guarded by a timeout, and returns each result and its flags over a ready/valid response port. Sticky exception flags accumulate across operations until software clears them.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 15: maximum cycles spent waiting for `alu_valid`; ≥1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  equals `!fifo_full`.
- `cmd_a`, `cmd_b`  in  32  operands.
- `cmd_op`  in  2  00 add, 01 sub, 10 mul, 11 div.
- `cmd_mode`  in  1  0 half, 1 single.
- `cmd_rnd`  in  1  rounding mode.
- `alu_start`  out  1  one-cycle issue pulse to the ALU.
- `alu_a`, `alu_b`  out  32  registered operands.
- `alu_op`  out  2  registered opcode.
- `alu_mode`, `alu_rnd`  out  1  registered mode and rounding bits.
- `alu_result`  in  32  ALU result.
- `alu_valid`  in  1  ALU result valid.
- `alu_flags`  in  5  {invalid, overflow, underflow, div_zero, inexact}.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  32  captured result.
- `rsp_flags`  out  5  captured flags.
- `rsp_timeout`  out  1  response produced by timeout.
- `sticky_flags`  out  5  OR of all captured `alu_flags` since last clear.
- `sticky_clr`  in  1  clears sticky flags.
- `busy`  out  1  `state != IDLE` or FIFO non-empty.

## Operation
- Reset: FIFO empty, state IDLE, wait counter 0; all registered outputs 0; `cmd_ready`=1.
- FIFO:
  - Push on `cmd_valid && cmd_ready`; pop only in IDLE.
  - `cmd_ready` derives from registered full, so a pop does not enable a push in the same cycle.
  - Issue uses registered empty, so a push into an empty FIFO is issued the next cycle.
  - Strict in-order processing.
- FSM:
  - IDLE: if FIFO non-empty, load `alu_*` from the head, pop, go to ISSUE.
  - ISSUE: `alu_start`=1 for exactly this cycle; clear counter; go to WAIT.
  - WAIT:
    - On `alu_valid`, capture `rsp_result`=`alu_result` and `rsp_flags`=`alu_flags`, set `rsp_timeout`=0, go to RESP.
    - Otherwise increment the counter. At counter==`TIMEOUT`-1 with no valid, set `rsp_result`=0, `rsp_flags`=0, `rsp_timeout`=1, go to RESP.
    - `alu_valid` in the timeout cycle wins and is a normal capture.
  - RESP: `rsp_valid`=1; `rsp_*` held stable until `rsp_ready`. On handshake, `rsp_valid` drops and the FSM goes to IDLE.
- `alu_valid` outside WAIT is ignored.
- `alu_*` operand outputs hold their value after issue until the next load.
- Sticky flags:
  - On a normal capture, `sticky_flags |= alu_flags`.
  - A timeout does not modify them.
  - `sticky_clr` alone sets them to 0.
  - `sticky_clr` in a capture cycle sets them to the captured `alu_flags`.
- Async reset mid-operation: queued and in-flight commands are discarded; a late `alu_valid` is ignored; no response is produced.

## Timing
- ALU contract: the ALU samples `alu_start` at edge N and raises `alu_valid` in the cycle after edge N.
- Command accepted at edge E0:
  - pop at E1;
  - `alu_start` high E1–E2;
  - capture at E3;
  - `rsp_valid` high from E3, i.e. 3 cycles after the accept edge.
- Minimum 4 cycles per operation (IDLE, ISSUE, WAIT, RESP) with `rsp_ready` held high.
- Timeout case: WAIT lasts exactly `TIMEOUT` cycles.
- `rsp_ready` low stalls the FSM in RESP. No new `alu_start` is issued, while the FIFO keeps accepting until full.

## Test plan
- Single add: `cmd_a`=0x3F800000, `cmd_b`=0x40000000, op 00, mode 1, ALU model returns 0x40400000 with flags 0 → `alu_start` is a one-cycle pulse, `rsp_valid` 3 cycles after accept, `rsp_result`=0x40400000, `rsp_flags`=0, `sticky_flags`=0.
- Backpressure/full: `rsp_ready`=0 while pushing 6 back-to-back commands → `cmd_ready` drops once 4 entries are queued; first response held stable; releasing `rsp_ready` returns all 6 in order with no extra `alu_start` pulses.
- Timeout: ALU model never asserts valid → `rsp_timeout`=1, `rsp_result`=0, `rsp_flags`=0 after exactly 15 WAIT cycles; `sticky_flags` unchanged; next command proceeds normally.
- Sticky:
  - div 1.0/0.0 returning flags 5'b00010, then mul returning 5'b01001 → `sticky_flags`=5'b01011;
  - `sticky_clr` in a capture cycle returning 5'b00001 → `sticky_flags`=5'b00001.
- Late valid: `alu_valid` asserted in the same cycle the counter hits `TIMEOUT`-1 → normal capture, `rsp_timeout`=0.
- Reset in WAIT with 2 commands queued → all outputs 0, `cmd_ready`=1, `busy`=0; subsequent `alu_valid` pulses produce no response.
